mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-input datapath mux between REQUESTERS masters.
- Drives the mux select (sel) and a one-hot grant back to the requesters.
- Holds ownership while the owner keeps requesting, up to a programmable hold limit for fairness.
- Sits between bus/execution-unit masters in the MPU core and the shared mux feeding a common resource (e.g. memory port or writeback bus).

Parameters:
- REQUESTERS, 4, number of requesters and mux inputs; minimum 2.
- SEL_WIDTH, clog2(REQUESTERS), mux select width; matches the mux ADDR_WIDTH.
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 means unlimited.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  REQUESTERS  request vector; bit i asserted by requester i.
- grant  output  REQUESTERS  registered one-hot grant; all zero when idle.
- sel  output  SEL_WIDTH  registered mux select, equal to the index of the granted requester.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset, asynchronous, applied immediately without a clock edge:
  - state=IDLE, grant=0, sel=0, busy=0, hold_cnt=0.
  - last pointer = REQUESTERS-1, so requester 0 has highest priority first.
- Arbitration function:
  - Search req starting at (last+1) mod REQUESTERS, ascending with wrap-around.
  - The first asserted bit wins.
- IDLE state:
  - If req != 0 at the edge: grant the winner, sel=winner index, busy=1, last=winner, hold_cnt=1, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency from req assertion to grant is 1 cycle.
- GRANT state, let o = current owner:
  - If req[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD): keep the grant; hold_cnt increments, saturating at MAX_HOLD.
  - If req[o]=0 or hold_cnt==MAX_HOLD (MAX_HOLD≠0): re-arbitrate this edge, with the search starting at o+1.
    - Winner found: the grant switches directly to the winner, with no idle cycle; last=winner, hold_cnt=1.
    - If the winner is o itself (sole requester at the hold limit), it is regranted: grant stays continuous and hold_cnt restarts at 1.
    - No winner: go to IDLE; grant=0, busy=0.
- sel in IDLE keeps the last owner index; the mux output is don't-care while busy=0.
- Requests are sampled only at clock edges; a req pulse that falls between edges is lost.
- Invariants:
  - grant is always one-hot or zero.
  - busy == |grant.
  - sel == index of the set grant bit whenever busy=1.
- hold_cnt width is clog2(MAX_HOLD+1); with MAX_HOLD=0 the counter is not used.
- The arbiter holds no per-requester memory: a requester that drops req loses its turn.

Test Plan (REQUESTERS=4, MAX_HOLD=3 unless noted):
1. Reset:
   - Stimulus: assert rst with req=1111, no clock.
   - Response: grant=0000, sel=0, busy=0 immediately.
   - Release rst: first edge gives grant=0001, sel=0.
2. Single requester:
   - Stimulus: req=0100 from edge 0.
   - Response: edge 1 grant=0100, sel=2, busy=1.
   - Drop req: the next edge gives grant=0000, busy=0, sel stays 2.
3. Fair rotation:
   - Stimulus: req=1111 held constantly.
   - Response: grant=0001 for 3 cycles, then 0010 ×3, 0100 ×3, 1000 ×3, then 0001 again.
   - busy stays continuously 1 throughout.
4. Zero-bubble handoff:
   - Stimulus: owner=1 (grant=0010), req changes to 1001.
   - Response: next edge grant=1000, sel=3; no cycle with grant=0.
5. Sole requester at the hold limit:
   - Stimulus: req=0010 only, held for 10 cycles.
   - Response: grant=0010 continuously; hold_cnt cycles 1,2,3,1,2,3…
   - Repeat with MAX_HOLD=0: grant is held for all 10 cycles and hold_cnt is unused.
6. Reset mid-operation:
   - Stimulus: assert rst asynchronously during grant=0100.
   - Response: outputs clear at once.
   - After release with req=1110: grant=0010, showing the pointer was reset.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared N:1 mux; registered grant/sel one cycle after req is sampled.
// No backpressure: req is sampled every edge, and a requester that drops req loses its turn.
module mux_rr_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int SEL_WIDTH  = $clog2(REQUESTERS),
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] req,
  output logic [REQUESTERS-1:0] grant,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  busy
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [SEL_WIDTH-1:0] LAST_INIT = SEL_WIDTH'(REQUESTERS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_nxt;
  logic [REQUESTERS-1:0]   grant_nxt;
  logic [SEL_WIDTH-1:0]    sel_nxt;
  logic                    busy_nxt;
  logic [SEL_WIDTH-1:0]    last, last_nxt;
  logic [HOLD_W-1:0]       hold_cnt, hold_nxt;
  logic                    win_vld;
  logic [SEL_WIDTH-1:0]    win_idx;
  logic                    keep;

  // Search starts just after the last winner; in GRANT that is the current owner.
  always_comb begin
    int                   idx;
    logic [SEL_WIDTH-1:0] idx_s;
    idx     = 0;
    idx_s   = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx   = (int'(last) + i) % REQUESTERS;
      idx_s = SEL_WIDTH'(idx);
      if (!win_vld && req[idx_s]) begin
        win_vld = 1'b1;
        win_idx = idx_s;
      end
    end
  end

  assign keep = req[sel] && ((MAX_HOLD == 0) || (hold_cnt < HOLD_MAX));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    busy_nxt  = busy;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          grant_nxt = {{(REQUESTERS-1){1'b0}}, 1'b1} << win_idx;
          sel_nxt   = win_idx;
          busy_nxt  = 1'b1;
          last_nxt  = win_idx;
          hold_nxt  = (MAX_HOLD != 0) ? HOLD_W'(1) : '0;
        end
      end
      GRANT: begin
        if (keep) begin
          if (MAX_HOLD != 0) hold_nxt = hold_cnt + 1'b1;
        end else if (win_vld) begin
          // Direct handoff (possibly back to the same owner) keeps grant continuous.
          grant_nxt = {{(REQUESTERS-1){1'b0}}, 1'b1} << win_idx;
          sel_nxt   = win_idx;
          last_nxt  = win_idx;
          hold_nxt  = (MAX_HOLD != 0) ? HOLD_W'(1) : '0;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          hold_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      last     <= LAST_INIT;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: one instance with MAX_HOLD=3, one with MAX_HOLD=0, shared stimulus.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant, grant_u;
  logic [1:0] sel, sel_u;
  logic       busy, busy_u;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic [1:0] h;
  } exp_t;

  exp_t sb[$];

  mux_rr_arbiter #(.REQUESTERS(4), .MAX_HOLD(3)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel), .busy(busy)
  );

  mux_rr_arbiter #(.REQUESTERS(4), .MAX_HOLD(0)) dut_u (
    .clk(clk), .rst(rst), .req(req), .grant(grant_u), .sel(sel_u), .busy(busy_u)
  );

  always #5 clk = ~clk;

  // Queue the expected post-edge result, apply req, then land 1 time unit after the edge.
  task automatic drive(input logic [3:0] r, input exp_t e);
    sb.push_back(e);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    req = 4'b1111;
    #2;
    checks++;
    if ({grant, sel, busy} !== {4'b0000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs grant=%b sel=%0d busy=%b, want 0000/0/0", grant, sel, busy);
    end
    checks++;
    if (dut.hold_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold hold_cnt=%0d, want 0", dut.hold_cnt);
    end
    #1;
    rst = 1'b0;
    drive(4'b1111, '{4'b0001, 2'd0, 1'b1, 2'd1});
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.g, e.s, e.b}) begin
      errors++;
      $display("FAIL reset_first_grant grant=%b sel=%0d busy=%b, want %b/%0d/%b",
               grant, sel, busy, e.g, e.s, e.b);
    end
  endtask

  task automatic test_single();
    logic [3:0] rq[3];
    exp_t       ex[3];
    exp_t       e;
    rq = '{4'b0100, 4'b0000, 4'b0101};
    ex = '{'{4'b0100, 2'd2, 1'b1, 2'd1},
           '{4'b0000, 2'd2, 1'b0, 2'd0},
           '{4'b0001, 2'd0, 1'b1, 2'd1}};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(rq[i], ex[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy} !== {e.g, e.s, e.b}) begin
        errors++;
        $display("FAIL single[%0d] grant=%b sel=%0d busy=%b, want %b/%0d/%b",
                 i, grant, sel, busy, e.g, e.s, e.b);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive(4'b1111, '{4'(1 << ((k / 3) % 4)), 2'((k / 3) % 4), 1'b1, 2'(k % 3 + 1)});
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy, dut.hold_cnt} !== {e.g, e.s, e.b, e.h}) begin
        errors++;
        $display("FAIL rotation[%0d] grant=%b sel=%0d busy=%b hold=%0d, want %b/%0d/%b/%0d",
                 k, grant, sel, busy, dut.hold_cnt, e.g, e.s, e.b, e.h);
      end
    end
  endtask

  task automatic test_handoff();
    logic [3:0] rq[2];
    exp_t       ex[2];
    exp_t       e;
    rq = '{4'b0010, 4'b1001};
    ex = '{'{4'b0010, 2'd1, 1'b1, 2'd1},
           '{4'b1000, 2'd3, 1'b1, 2'd1}};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(rq[i], ex[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy} !== {e.g, e.s, e.b}) begin
        errors++;
        $display("FAIL handoff[%0d] grant=%b sel=%0d busy=%b, want %b/%0d/%b",
                 i, grant, sel, busy, e.g, e.s, e.b);
      end
    end
  endtask

  task automatic test_hold_limit();
    exp_t e;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(4'b0010, '{4'b0010, 2'd1, 1'b1, 2'(k % 3 + 1)});
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy, dut.hold_cnt} !== {e.g, e.s, e.b, e.h}) begin
        errors++;
        $display("FAIL hold_limit[%0d] grant=%b sel=%0d busy=%b hold=%0d, want %b/%0d/%b/%0d",
                 k, grant, sel, busy, dut.hold_cnt, e.g, e.s, e.b, e.h);
      end
      checks++;
      if ({grant_u, sel_u, busy_u} !== {4'b0010, 2'd1, 1'b1}) begin
        errors++;
        $display("FAIL hold_unlimited[%0d] grant=%b sel=%0d busy=%b, want 0010/1/1",
                 k, grant_u, sel_u, busy_u);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    drive(4'b0100, '{4'b0100, 2'd2, 1'b1, 2'd1});
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.g, e.s, e.b}) begin
      errors++;
      $display("FAIL midreset_pre grant=%b sel=%0d busy=%b, want %b/%0d/%b",
               grant, sel, busy, e.g, e.s, e.b);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({grant, sel, busy} !== {4'b0000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_clear grant=%b sel=%0d busy=%b, want 0000/0/0", grant, sel, busy);
    end
    rst = 1'b0;
    drive(4'b1110, '{4'b0010, 2'd1, 1'b1, 2'd1});
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.g, e.s, e.b}) begin
      errors++;
      $display("FAIL midreset_pointer grant=%b sel=%0d busy=%b, want %b/%0d/%b",
               grant, sel, busy, e.g, e.s, e.b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_handoff();
    test_hold_limit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
